pr_region_sequencer: RTL and testbench

- Sequences partial reconfiguration of one of NUM_REGIONS PR regions at a time.
- A host command selects a region. The block then runs, in order: stop handshake to the region, freeze of its boundary, a program request to the PR engine, unfreeze, and start handshake. It returns one status code per command.
- Sits between the host CSR/command path, the per-region stop/start handshake endpoints and the device PR controller IP. Only one region is ever under reconfiguration.

---
 rtl/pr_region_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pr_region_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_region_sequencer.sv
// Partial-reconfiguration sequencer: per host command it stops, freezes, programs,
// unfreezes and restarts one PR region, then reports a single status code.
module pr_region_sequencer #(
  parameter int NUM_REGIONS = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [IDX_W-1:0]       cmd_region,
  output logic                   cmd_ready,
  output logic                   status_valid,
  output logic [2:0]             status_code,
  output logic                   busy,
  output logic [NUM_REGIONS-1:0] stop_req,
  input  logic [NUM_REGIONS-1:0] stop_ack,
  output logic [NUM_REGIONS-1:0] start_req,
  input  logic [NUM_REGIONS-1:0] start_ack,
  output logic [NUM_REGIONS-1:0] freeze,
  output logic                   pr_start,
  output logic [IDX_W-1:0]       pr_region,
  input  logic                   pr_done,
  input  logic                   pr_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_STOP, S_FRZ, S_PR, S_UNFRZ, S_START, S_REPORT
  } state_e;

  localparam logic [2:0] CODE_OK       = 3'd0;
  localparam logic [2:0] CODE_STOP_TO  = 3'd1;
  localparam logic [2:0] CODE_PR_ERR   = 3'd2;
  localparam logic [2:0] CODE_START_TO = 3'd3;
  localparam logic [2:0] CODE_BAD_IDX  = 3'd4;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIM = TIMEOUT_W'(TIMEOUT_CYC);

  state_e                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]       pr_region_q, pr_region_d;
  logic                   err_q, err_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   status_valid_q, status_valid_d;
  logic [2:0]             status_code_q, status_code_d;
  logic [NUM_REGIONS-1:0] stop_req_q, stop_req_d;
  logic [NUM_REGIONS-1:0] start_req_q, start_req_d;
  logic [NUM_REGIONS-1:0] freeze_q, freeze_d;
  logic                   pr_start_q, pr_start_d;

  logic [NUM_REGIONS-1:0] region_mask;
  logic [TIMEOUT_W-1:0]   cnt_inc;
  logic                   cnt_expired;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch can be inferred.
    state_d       = state_q;
    cnt_d         = cnt_q;
    pr_region_d   = pr_region_q;
    err_d         = err_q;
    status_code_d = status_code_q;

    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + TIMEOUT_W'(1);
    cnt_expired = (cnt_inc >= TIMEOUT_LIM);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          pr_region_d = cmd_region;
          err_d       = 1'b0;
          cnt_d       = '0;
          if (int'(cmd_region) >= NUM_REGIONS) begin
            state_d       = S_REPORT;
            status_code_d = CODE_BAD_IDX;
          end else begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (|(stop_ack & region_mask_of(pr_region_q))) begin
          state_d = S_FRZ;
        end else if (cnt_expired) begin
          state_d       = S_REPORT;
          status_code_d = CODE_STOP_TO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_FRZ: state_d = S_PR;
      S_PR: begin
        // An error in the same cycle as done must still be reported.
        if (pr_error) begin
          err_d   = 1'b1;
          state_d = S_UNFRZ;
        end else if (pr_done) begin
          state_d = S_UNFRZ;
        end
      end
      S_UNFRZ: begin
        state_d = S_START;
        cnt_d   = '0;
      end
      S_START: begin
        if (|(start_ack & region_mask_of(pr_region_q))) begin
          state_d       = S_REPORT;
          status_code_d = err_q ? CODE_PR_ERR : CODE_OK;
        end else if (cnt_expired) begin
          state_d       = S_REPORT;
          status_code_d = CODE_START_TO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are a registered decode of the next state, so each one is a clean flop.
    region_mask    = region_mask_of(pr_region_d);
    stop_req_d     = (state_d == S_STOP)  ? region_mask : '0;
    start_req_d    = (state_d == S_START) ? region_mask : '0;
    freeze_d       = (state_d == S_FRZ || state_d == S_PR) ? region_mask : '0;
    pr_start_d     = (state_q == S_FRZ);
    status_valid_d = (state_d == S_REPORT);
    cmd_ready_d    = (state_d == S_IDLE);
    busy_d         = (state_d != S_IDLE);
  end

  function automatic logic [NUM_REGIONS-1:0] region_mask_of(input logic [IDX_W-1:0] idx);
    return NUM_REGIONS'(1) << idx;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      pr_region_q    <= '0;
      err_q          <= 1'b0;
      cmd_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      status_valid_q <= 1'b0;
      status_code_q  <= '0;
      stop_req_q     <= '0;
      start_req_q    <= '0;
      freeze_q       <= '0;
      pr_start_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pr_region_q    <= pr_region_d;
      err_q          <= err_d;
      cmd_ready_q    <= cmd_ready_d;
      busy_q         <= busy_d;
      status_valid_q <= status_valid_d;
      status_code_q  <= status_code_d;
      stop_req_q     <= stop_req_d;
      start_req_q    <= start_req_d;
      freeze_q       <= freeze_d;
      pr_start_q     <= pr_start_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign status_valid = status_valid_q;
  assign status_code  = status_code_q;
  assign stop_req     = stop_req_q;
  assign start_req    = start_req_q;
  assign freeze       = freeze_q;
  assign pr_start     = pr_start_q;
  assign pr_region    = pr_region_q;

endmodule

// File: tb/tb_pr_region_sequencer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized commands against a transaction-level model of the sequencer.
module tb_pr_region_sequencer;

  localparam int NR      = 4;
  localparam int TO      = 8;
  localparam int MAX_CYC = 200;
  localparam int NRAND   = 40;

  typedef enum int {PR_DONE, PR_ERR, PR_BOTH} pr_kind_e;
  // ds/da: ack delay in cycles after the request first appears, 0 = never acked.
  // dp: cycles from pr_start to the PR engine result pulse.
  typedef struct {
    int       region;
    int       ds;
    pr_kind_e kind;
    int       dp;
    int       da;
  } cmd_t;
  typedef struct {
    int code;
    int t_status;
    int n_status;
    int n_stop;
    int n_freeze;
    int n_prstart;
    int t_prstart;
    int n_start;
    int viol;
    int idle_ok;
  } res_t;
  typedef struct {
    cmd_t c;
    int   exp_code;
    int   exp_t_status;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [1:0]    cmd_region;
  logic          cmd_ready, status_valid, busy, pr_start;
  logic [2:0]    status_code;
  logic [NR-1:0] stop_req, stop_ack, start_req, start_ack, freeze;
  logic [1:0]    pr_region;
  logic          pr_done, pr_error;

  logic          b_cmd_valid;
  logic [1:0]    b_cmd_region;
  logic          b_cmd_ready, b_status_valid, b_busy, b_pr_start;
  logic [2:0]    b_status_code;
  logic [2:0]    b_stop_req, b_start_req, b_freeze;
  logic [2:0]    b_stop_ack, b_start_ack;
  logic [1:0]    b_pr_region;
  logic          b_pr_done, b_pr_error;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pr_region_sequencer #(.NUM_REGIONS(NR), .IDX_W(2), .TIMEOUT_W(16), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_region(cmd_region),
    .cmd_ready(cmd_ready), .status_valid(status_valid), .status_code(status_code),
    .busy(busy), .stop_req(stop_req), .stop_ack(stop_ack), .start_req(start_req),
    .start_ack(start_ack), .freeze(freeze), .pr_start(pr_start), .pr_region(pr_region),
    .pr_done(pr_done), .pr_error(pr_error)
  );

  pr_region_sequencer #(.NUM_REGIONS(3), .IDX_W(2), .TIMEOUT_W(8), .TIMEOUT_CYC(TO)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_region(b_cmd_region),
    .cmd_ready(b_cmd_ready), .status_valid(b_status_valid), .status_code(b_status_code),
    .busy(b_busy), .stop_req(b_stop_req), .stop_ack(b_stop_ack), .start_req(b_start_req),
    .start_ack(b_start_ack), .freeze(b_freeze), .pr_start(b_pr_start), .pr_region(b_pr_region),
    .pr_done(b_pr_done), .pr_error(b_pr_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level expectation: status code and phase lengths from the handshake rules.
  function automatic res_t model(input cmd_t c);
    res_t e;
    bit   stop_ok, start_ok, err;
    e = '{default: 0};
    e.n_status  = 1;
    e.idle_ok   = 1;
    e.t_prstart = -1;
    stop_ok  = (c.ds != 0) && (c.ds < TO);
    e.n_stop = stop_ok ? c.ds + 1 : TO;
    if (!stop_ok) begin
      e.code     = 1;
      e.t_status = e.n_stop;
    end else begin
      err         = (c.kind != PR_DONE);
      start_ok    = (c.da != 0) && (c.da < TO);
      e.n_prstart = 1;
      e.t_prstart = e.n_stop + 1;
      e.n_freeze  = c.dp + 2;
      e.n_start   = start_ok ? c.da + 1 : TO;
      e.t_status  = e.n_stop + c.dp + 3 + e.n_start;
      e.code      = !start_ok ? 3 : (err ? 2 : 0);
    end
    return e;
  endfunction

  // Issue one command to dut and play the region endpoints and PR engine.
  // With noise set: ignored ack bits of other regions, stray PR pulses outside PR,
  // and random cmd_valid while busy.
  task automatic run_cmd(input cmd_t c, input bit noise, output res_t o);
    logic [NR-1:0] m;
    int  first_stop, first_start, p0, ts;
    bit  fin;
    m = NR'(1) << c.region;
    o = '{default: 0};
    o.t_status  = -1;
    o.t_prstart = -1;
    first_stop = -1; first_start = -1; p0 = -1; ts = -1; fin = 1'b0;
    cmd_valid  = 1'b1;
    cmd_region = 2'(c.region);
    @(posedge clk);
    for (int j = 0; j < MAX_CYC && !fin; j++) begin
      @(negedge clk);
      if (stop_req != '0 && stop_req != m) o.viol++;
      if (start_req != '0 && start_req != m) o.viol++;
      if (freeze != '0 && freeze != m) o.viol++;
      if (busy && pr_region != 2'(c.region)) o.viol++;
      if (stop_req != '0) begin
        o.n_stop++;
        if (first_stop < 0) first_stop = j;
      end
      if (start_req != '0) begin
        o.n_start++;
        if (first_start < 0) first_start = j;
      end
      if (freeze != '0) o.n_freeze++;
      if (pr_start) begin
        o.n_prstart++;
        if (p0 < 0) begin p0 = j; o.t_prstart = j; end
      end
      if (status_valid) begin
        o.n_status++;
        if (ts < 0) begin ts = j; o.t_status = j; o.code = int'(status_code); end
      end

      stop_ack  = (noise ? NR'($urandom) & ~m : '0) |
                  ((stop_req != '0 && c.ds != 0 && j - first_stop >= c.ds) ? m : '0);
      start_ack = (noise ? NR'($urandom) & ~m : '0) |
                  ((start_req != '0 && c.da != 0 && j - first_start >= c.da) ? m : '0);
      pr_done  = 1'b0;
      pr_error = 1'b0;
      if (p0 >= 0 && j == p0 + c.dp) begin
        pr_done  = (c.kind != PR_ERR);
        pr_error = (c.kind != PR_DONE);
      end else if (noise && (stop_req != '0 || start_req != '0) && $urandom_range(0, 3) == 0) begin
        pr_done  = 1'($urandom_range(0, 1));
        pr_error = 1'($urandom_range(0, 1));
      end

      if (ts >= 0 && j == ts + 1) begin
        fin       = 1'b1;
        o.idle_ok = int'(cmd_ready && !busy);
        cmd_valid = 1'b0;
        stop_ack  = '0;
        start_ack = '0;
        pr_done   = 1'b0;
        pr_error  = 1'b0;
      end else begin
        cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) cmd_region = 2'($urandom);
      end
    end
  endtask

  task automatic compare(input string tag, input res_t g, input res_t e);
    check({tag, ".code"},      g.code,      e.code);
    check({tag, ".t_status"},  g.t_status,  e.t_status);
    check({tag, ".n_status"},  g.n_status,  e.n_status);
    check({tag, ".n_stop"},    g.n_stop,    e.n_stop);
    check({tag, ".n_freeze"},  g.n_freeze,  e.n_freeze);
    check({tag, ".n_prstart"}, g.n_prstart, e.n_prstart);
    check({tag, ".t_prstart"}, g.t_prstart, e.t_prstart);
    check({tag, ".n_start"},   g.n_start,   e.n_start);
    check({tag, ".viol"},      g.viol,      e.viol);
    check({tag, ".idle"},      g.idle_ok,   e.idle_ok);
  endtask

  vec_t vecs[8];
  res_t got, exp_r;
  cmd_t rc;
  bit   seen;
  int   cnt_a, cnt_b;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{'{2, 1, PR_DONE, 10, 1}, 0, 17};
    vecs[1] = '{'{1, 0, PR_DONE, 0, 1},  1, 8};
    vecs[2] = '{'{0, 1, PR_ERR, 3, 1},   2, 10};
    vecs[3] = '{'{3, 2, PR_BOTH, 0, 1},  2, 8};
    vecs[4] = '{'{2, 1, PR_ERR, 2, 0},   3, 15};
    vecs[5] = '{'{1, 7, PR_DONE, 1, 7},  0, 20};
    vecs[6] = '{'{0, 8, PR_DONE, 0, 1},  1, 8};
    vecs[7] = '{'{3, 1, PR_DONE, 0, 8},  3, 13};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_region = '0; stop_ack = '0; start_ack = '0;
    pr_done = 1'b0; pr_error = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_region = '0; b_stop_ack = '0; b_start_ack = '0;
    b_pr_done = 1'b0; b_pr_error = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst.cmd_ready", cmd_ready, 1);
    check("rst.busy_status", {busy, status_valid, pr_start, status_code, pr_region}, 0);
    check("rst.reqs", {stop_req, start_req, freeze}, 0);
    check("rst.b_ready_busy", {b_cmd_ready, b_busy}, 2'b10);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].c, 1'b0, got);
      exp_r = model(vecs[i].c);
      check($sformatf("vec%0d.table_code", i), got.code, vecs[i].exp_code);
      check($sformatf("vec%0d.table_t", i), got.t_status, vecs[i].exp_t_status);
      compare($sformatf("vec%0d", i), got, exp_r);
    end

    // Reset while the region is frozen in PR; a late pr_done must be ignored.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_region = 2'd1; stop_ack = 4'b0010;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (pr_start) seen = 1'b1;
    end
    check("rstpr.reached_pr", seen, 1);
    stop_ack = '0;
    @(negedge clk);
    check("rstpr.frozen", freeze, 4'b0010);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstpr.outputs", {freeze, stop_req, start_req}, 0);
    check("rstpr.ready_busy", {cmd_ready, busy, status_valid}, 3'b100);
    pr_done = 1'b1;
    @(negedge clk);
    pr_done = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 6; k++) begin
      if (status_valid) cnt_a++;
      if (busy || freeze != '0 || start_req != '0 || pr_start) cnt_b++;
      @(negedge clk);
    end
    check("rstpr.no_status", cnt_a, 0);
    check("rstpr.stays_idle", cnt_b, 0);

    // Three-region instance: index 3 is bad, cmd_valid held into REPORT is ignored.
    b_cmd_valid = 1'b1; b_cmd_region = 2'd3;
    @(negedge clk);
    check("bad.status", {b_status_valid, b_status_code}, {1'b1, 3'd4});
    check("bad.ready_busy", {b_cmd_ready, b_busy}, 2'b01);
    cnt_a = 1; cnt_b = 0;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    check("bad.idle_again", {b_cmd_ready, b_busy}, 2'b10);
    for (int k = 0; k < 5; k++) begin
      if (b_status_valid) cnt_a++;
      if (b_stop_req != '0 || b_start_req != '0 || b_freeze != '0 || b_pr_start || b_busy) cnt_b++;
      @(negedge clk);
    end
    check("bad.one_status", cnt_a, 1);
    check("bad.no_req", cnt_b, 0);

    // Highest legal index on the three-region instance, never acked.
    b_cmd_valid = 1'b1; b_cmd_region = 2'd2;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    check("b2.stop_req", b_stop_req, 3'b100);
    seen = 1'b0; cnt_a = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (b_stop_req != '0) cnt_a++;
      if (b_status_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("b2.status_seen", seen, 1);
    check("b2.code", b_status_code, 1);
    check("b2.stop_cycles", cnt_a, TO);

    for (int n = 0; n < NRAND; n++) begin
      rc.region = int'($urandom_range(0, NR - 1));
      rc.ds     = int'($urandom_range(0, 9));
      rc.kind   = pr_kind_e'($urandom_range(0, 2));
      rc.dp     = int'($urandom_range(0, 12));
      rc.da     = int'($urandom_range(0, 9));
      run_cmd(rc, 1'b1, got);
      exp_r = model(rc);
      compare($sformatf("rnd%0d", n), got, exp_r);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
